// File: rtl/psram_arbiter_if.sv
// Request/response and PSRAM pin bundle for psram_arbiter.
// master: requesters plus the PSRAM read data; slave: the arbiter itself.
interface psram_arbiter_if;
  logic        rd_req;
  logic [22:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;

  logic        wr_req;
  logic [22:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_gnt;
  logic        wr_done;

  logic [22:0] mem_addr;
  logic [15:0] mem_dq_out;
  logic        mem_dq_oe;
  logic [15:0] mem_dq_in;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_dq_in,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, wr_done,
    input  mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_dq_in,
    output rd_gnt, rd_valid, rd_data, wr_gnt, wr_done,
    output mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-requester arbiter for a single asynchronous PSRAM port.
// Display reads win by default; a starvation counter forces a host write
// after STARVE_MAX consecutive reads granted while a write was waiting.
module psram_arbiter #(
  parameter int ACCESS_CYCLES  = 8,
  parameter int RECOVER_CYCLES = 1,
  parameter int STARVE_MAX     = 4
) (
  input  logic            clk,
  input  logic            reset,
  psram_arbiter_if.slave  bus
);

  localparam int CNT_TOP = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam int SW      = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] starve, starve_n;

  logic        rd_gnt_q, rd_gnt_n;
  logic        rd_valid_q, rd_valid_n;
  logic [15:0] rd_data_q, rd_data_n;
  logic        wr_gnt_q, wr_gnt_n;
  logic        wr_done_q, wr_done_n;
  logic [22:0] addr_q, addr_n;
  logic [15:0] dqo_q, dqo_n;
  logic        dq_oe_q, dq_oe_n;
  logic        ce_n_q, ce_n_n;
  logic        oe_n_q, oe_n_n;
  logic        we_n_q, we_n_n;

  // State, counters and every output come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      starve     <= '0;
      rd_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_gnt_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      addr_q     <= '0;
      dqo_q      <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      starve     <= starve_n;
      rd_gnt_q   <= rd_gnt_n;
      rd_valid_q <= rd_valid_n;
      rd_data_q  <= rd_data_n;
      wr_gnt_q   <= wr_gnt_n;
      wr_done_q  <= wr_done_n;
      addr_q     <= addr_n;
      dqo_q      <= dqo_n;
      dq_oe_q    <= dq_oe_n;
      ce_n_q     <= ce_n_n;
      oe_n_q     <= oe_n_n;
      we_n_q     <= we_n_n;
    end
  end

  // Next state plus next value of each registered output.
  // The grant cycle is cnt=0 (address latched, strobes still idle); the
  // strobes for access cycle k are computed while cnt=k-1 so they land
  // registered, giving k=1..ACCESS_CYCLES after the grant pulse.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    starve_n   = starve;
    rd_gnt_n   = 1'b0;
    rd_valid_n = 1'b0;
    rd_data_n  = rd_data_q;
    wr_gnt_n   = 1'b0;
    wr_done_n  = 1'b0;
    addr_n     = addr_q;
    dqo_n      = dqo_q;
    dq_oe_n    = 1'b0;
    ce_n_n     = 1'b1;
    oe_n_n     = 1'b1;
    we_n_n     = 1'b1;

    case (state)
      IDLE: begin
        if (bus.rd_req && !(bus.wr_req && starve == SW'(STARVE_MAX))) begin
          state_n  = READ;
          cnt_n    = '0;
          rd_gnt_n = 1'b1;
          addr_n   = bus.rd_addr;
          if (bus.wr_req) starve_n = starve + SW'(1);
        end else if (bus.wr_req) begin
          state_n  = WRITE;
          cnt_n    = '0;
          wr_gnt_n = 1'b1;
          addr_n   = bus.wr_addr;
          dqo_n    = bus.wr_data;
          starve_n = '0;
        end
      end

      READ: begin
        if (cnt == CW'(ACCESS_CYCLES)) begin
          state_n    = RECOVER;
          cnt_n      = CW'(1);
          rd_data_n  = bus.mem_dq_in;
          rd_valid_n = 1'b1;
        end else begin
          cnt_n  = cnt + CW'(1);
          ce_n_n = 1'b0;
          oe_n_n = 1'b0;
        end
      end

      WRITE: begin
        if (cnt == CW'(ACCESS_CYCLES)) begin
          state_n   = RECOVER;
          cnt_n     = CW'(1);
          wr_done_n = 1'b1;
          dq_oe_n   = 1'b1;
        end else begin
          cnt_n   = cnt + CW'(1);
          ce_n_n  = 1'b0;
          dq_oe_n = 1'b1;
          we_n_n  = (cnt == '0);
        end
      end

      RECOVER: begin
        if (cnt == CW'(RECOVER_CYCLES)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.rd_gnt     = rd_gnt_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.wr_gnt     = wr_gnt_q;
  assign bus.wr_done    = wr_done_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_dq_out = dqo_q;
  assign bus.mem_dq_oe  = dq_oe_q;
  assign bus.mem_ce_n   = ce_n_q;
  assign bus.mem_oe_n   = oe_n_q;
  assign bus.mem_we_n   = we_n_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: vector table plus multi-cycle sequences.
module tb_psram_arbiter;
  logic clk;
  logic reset;
  int   cyc;

  psram_arbiter_if bus();

  psram_arbiter #(.ACCESS_CYCLES(8), .RECOVER_CYCLES(1), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [22:0] ra;
    logic [22:0] wa;
    logic [15:0] wd;
    logic [15:0] dq;
    logic        exp_w;
    logic [22:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_grant(output logic gr, output logic gw, output logic ok, output int t);
    ok = 1'b0; gr = 1'b0; gw = 1'b0; t = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rd_gnt || bus.wr_gnt) begin
        gr = bus.rd_gnt; gw = bus.wr_gnt; ok = 1'b1; t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic ok, output int t);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rd_valid || bus.wr_done) begin
        ok = 1'b1; t = cyc;
        break;
      end
    end
  endtask

  initial begin
    logic gr, gw, ok, dn, seen_done, seen_gnt, early;
    int   t0, t1, td, tg;
    int   we_low, oe_low, ce_low, dqoe_hi, addr_bad, done_at;
    logic gtype[10];
    int   gtime[10];
    int   ng, min_gap;
    logic exp_pat[10];

    n_chk = 0; n_pass = 0;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.mem_dq_in = '0;

    vecs[0] = '{1'b1, 1'b0, 23'h000100, 23'h0,      16'h0,    16'hBEEF, 1'b0, 23'h000100, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 23'h0,      23'h7FFFFF, 16'h1234, 16'h0,    1'b1, 23'h7FFFFF, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 23'h0000AA, 23'h000055, 16'hAAAA, 16'h5555, 1'b0, 23'h0000AA, 16'h5555};
    vecs[3] = '{1'b1, 1'b1, 23'h0000AB, 23'h000055, 16'hAAAA, 16'h1111, 1'b0, 23'h0000AB, 16'h1111};
    vecs[4] = '{1'b1, 1'b1, 23'h0000AC, 23'h000055, 16'hAAAA, 16'h2222, 1'b0, 23'h0000AC, 16'h2222};
    vecs[5] = '{1'b1, 1'b1, 23'h0000AD, 23'h000055, 16'hAAAA, 16'h3333, 1'b0, 23'h0000AD, 16'h3333};
    vecs[6] = '{1'b1, 1'b1, 23'h0000AE, 23'h000055, 16'hAAAA, 16'h4444, 1'b1, 23'h000055, 16'hAAAA};
    vecs[7] = '{1'b1, 1'b0, 23'h000000, 23'h0,      16'h0,    16'hFFFF, 1'b0, 23'h000000, 16'hFFFF};

    // reset state
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst ce_n", bus.mem_ce_n, 1);
    chk("rst oe_n", bus.mem_oe_n, 1);
    chk("rst we_n", bus.mem_we_n, 1);
    chk("rst dq_oe", bus.mem_dq_oe, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst dq_out", bus.mem_dq_out, 0);
    chk("rst rd_data", bus.rd_data, 0);
    chk("rst pulses", {bus.rd_gnt, bus.rd_valid, bus.wr_gnt, bus.wr_done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // vector table
    for (int v = 0; v < 8; v++) begin
      bus.mem_dq_in = vecs[v].dq;
      bus.rd_addr   = vecs[v].ra;
      bus.wr_addr   = vecs[v].wa;
      bus.wr_data   = vecs[v].wd;
      bus.rd_req    = vecs[v].rd;
      bus.wr_req    = vecs[v].wr;
      wait_grant(gr, gw, ok, t0);
      chk($sformatf("v%0d grant_seen", v), ok, 1);
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      if (ok) begin
        chk($sformatf("v%0d grant_is_write", v), gw, vecs[v].exp_w);
        chk($sformatf("v%0d single_grant", v), gr & gw, 0);
        chk($sformatf("v%0d mem_addr", v), bus.mem_addr, vecs[v].exp_addr);
        wait_done(dn, t1);
        chk($sformatf("v%0d done_seen", v), dn, 1);
        if (vecs[v].exp_w) begin
          chk($sformatf("v%0d dq_out", v), bus.mem_dq_out, vecs[v].exp_data);
        end else begin
          chk($sformatf("v%0d rd_data", v), bus.rd_data, vecs[v].exp_data);
          chk($sformatf("v%0d rd_latency", v), t1 - t0, 9);
        end
      end
      repeat (2) @(negedge clk);
    end

    // write strobe profile
    bus.wr_addr = 23'h7FFFFF; bus.wr_data = 16'h1234; bus.wr_req = 1'b1;
    wait_grant(gr, gw, ok, t0);
    chk("wprof grant", gw, 1);
    bus.wr_req = 1'b0;
    we_low = 0; oe_low = 0; ce_low = 0; dqoe_hi = 0; addr_bad = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.mem_we_n) we_low++;
      if (!bus.mem_oe_n) oe_low++;
      if (!bus.mem_ce_n) ce_low++;
      if (bus.mem_dq_oe) dqoe_hi++;
      if (bus.mem_addr != 23'h7FFFFF) addr_bad++;
      if (bus.wr_done) done_at = i;
    end
    chk("wprof we_low", we_low, 7);
    chk("wprof oe_low", oe_low, 0);
    chk("wprof ce_low", ce_low, 8);
    chk("wprof dq_oe_hi", dqoe_hi, 9);
    chk("wprof addr_held", addr_bad, 0);
    chk("wprof done_at", done_at, 8);

    // read strobe profile
    bus.rd_addr = 23'h000100; bus.mem_dq_in = 16'hBEEF; bus.rd_req = 1'b1;
    wait_grant(gr, gw, ok, t0);
    chk("rprof grant", gr, 1);
    bus.rd_req = 1'b0;
    we_low = 0; oe_low = 0; dqoe_hi = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.mem_we_n) we_low++;
      if (!bus.mem_oe_n) oe_low++;
      if (bus.mem_dq_oe) dqoe_hi++;
      if (bus.rd_valid) done_at = i;
    end
    chk("rprof oe_low", oe_low, 8);
    chk("rprof we_low", we_low, 0);
    chk("rprof dq_oe_hi", dqoe_hi, 0);
    chk("rprof valid_at", done_at, 8);

    // starvation guard: both held continuously
    exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.rd_req = 1'b1; bus.wr_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 200 && ng < 10; i++) begin
      @(negedge clk);
      if (bus.rd_gnt || bus.wr_gnt) begin
        gtype[ng] = bus.wr_gnt;
        gtime[ng] = cyc;
        ng++;
      end
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    chk("starve grant_count", ng, 10);
    min_gap = 1000;
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("starve grant%0d_is_write", i), gtype[i], exp_pat[i]);
      if (i > 0 && gtime[i] - gtime[i-1] < min_gap) min_gap = gtime[i] - gtime[i-1];
    end
    chk("starve min_gap_ok", min_gap >= 10, 1);
    repeat (15) @(negedge clk);

    // reset in the middle of a write, read pending
    bus.wr_addr = 23'h001000; bus.wr_data = 16'hCAFE; bus.wr_req = 1'b1;
    wait_grant(gr, gw, ok, t0);
    chk("rstw grant", gw, 1);
    bus.wr_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstw in_write_k4", bus.mem_we_n, 0);
    bus.rd_addr = 23'h000200; bus.mem_dq_in = 16'h0F0F; bus.rd_req = 1'b1;
    reset = 1'b1;
    #1;
    chk("rstw ce_n", bus.mem_ce_n, 1);
    chk("rstw we_n", bus.mem_we_n, 1);
    chk("rstw oe_n", bus.mem_oe_n, 1);
    chk("rstw dq_oe", bus.mem_dq_oe, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0; seen_gnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_done) seen_done = 1'b1;
      if (bus.rd_gnt) begin
        seen_gnt = 1'b1;
        break;
      end
    end
    bus.rd_req = 1'b0;
    chk("rstw no_wr_done", seen_done, 0);
    chk("rstw rd_gnt_after", seen_gnt, 1);
    wait_done(dn, t1);
    chk("rstw rd_data", bus.rd_data, 16'h0F0F);
    repeat (3) @(negedge clk);

    // read request arriving during a write waits for IDLE
    bus.wr_addr = 23'h002000; bus.wr_data = 16'h5A5A; bus.wr_req = 1'b1;
    wait_grant(gr, gw, ok, t0);
    chk("hold grant", gw, 1);
    bus.wr_req = 1'b0;
    repeat (3) @(negedge clk);
    bus.rd_addr = 23'h003000; bus.mem_dq_in = 16'hA5A5; bus.rd_req = 1'b1;
    td = -100; tg = 0; seen_done = 1'b0; seen_gnt = 1'b0; early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wr_done) begin
        seen_done = 1'b1; td = cyc;
      end
      if (bus.rd_gnt) begin
        if (!seen_done) early = 1'b1;
        seen_gnt = 1'b1; tg = cyc;
        break;
      end
    end
    bus.rd_req = 1'b0;
    chk("hold no_preempt", early, 0);
    chk("hold rd_gnt_seen", seen_gnt, 1);
    chk("hold gnt_after_done", tg - td, 2);
    wait_done(dn, t1);
    chk("hold rd_data", bus.rd_data, 16'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
